// File: rtl/life_grid_controller.sv
// life_grid_controller: owns the 8x8 Life grid, loads seeds row by row and
// commits evolve-datapath results by single step or free-running at STEP_DIV.
module life_grid_controller #(
    parameter int STEP_DIV = 4,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [7:0]       load_row,
    output logic             load_ready,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic [63:0]      grid_evolve,
    output logic [63:0]      grid,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             stable,
    output logic             extinct,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
    state_t state, state_nx;
    logic [2:0] idx;
    logic [15:0] tick;
    logic xfer, last_tick;
    logic [GEN_W-1:0] gen_inc;
    assign load_ready = (state == IDLE) || (state == LOAD);
    assign busy       = (state == LOAD) || (state == RUN);
    assign done       = (state == HALT);
    assign xfer       = load_valid && load_ready;
    assign last_tick  = tick == 16'(STEP_DIV - 1);
    assign gen_inc    = (&gen_count) ? gen_count : gen_count + 1'b1;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = xfer ? LOAD : start ? RUN : IDLE;
            LOAD: state_nx = (xfer && idx == 3'd7) ? IDLE : LOAD;
            RUN:  state_nx = (stop || (last_tick && (grid == '0 || grid_evolve == grid || &gen_inc))) ? HALT : RUN;
            HALT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grid      <= '0;
            gen_count <= '0;
            idx       <= '0;
            tick      <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                grid[{idx, 3'b000} +: 8] <= load_row;
                idx <= idx + 3'd1;
                if (state == IDLE) begin
                    gen_count <= '0;
                    stable    <= 1'b0;
                    extinct   <= 1'b0;
                end
            end else if (state == IDLE && start) begin
                stable  <= 1'b0;
                extinct <= 1'b0;
                tick    <= '0;
            end else if (state == IDLE && step) begin
                grid      <= grid_evolve;
                gen_count <= gen_inc;
            end else if (state == RUN && !stop) begin
                tick <= last_tick ? 16'd0 : tick + 16'd1;
                // Halt causes are checked before committing so a dead or still grid is never rewritten.
                if (last_tick) begin
                    if (grid == '0) extinct <= 1'b1;
                    else if (grid_evolve == grid) stable <= 1'b1;
                    else begin
                        grid      <= grid_evolve;
                        gen_count <= gen_inc;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_life_grid_controller.sv
// tb_life_grid_controller: directed checks of load, step, run/halt causes, stop and reset
// against a bounded (non-wrapping) Life model driving grid_evolve.
module tb_life_grid_controller;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic load_valid = 1'b0;
    logic [7:0] load_row = '0;
    logic load_ready;
    logic start = 1'b0, step = 1'b0, stop = 1'b0;
    logic [63:0] grid_evolve, grid;
    logic [15:0] gen_count;
    logic busy, stable, extinct, done;
    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;
    localparam logic [63:0] GLIDER2 = 64'h0000_0000_0605_0400;
    localparam logic [63:0] SEED    = 64'h8877_6655_4433_2211;

    always #5 clk = ~clk;

    life_grid_controller #(.STEP_DIV(4), .GEN_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_row(load_row),
        .load_ready(load_ready), .start(start), .step(step), .stop(stop),
        .grid_evolve(grid_evolve), .grid(grid), .gen_count(gen_count), .busy(busy),
        .stable(stable), .extinct(extinct), .done(done)
    );

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] nx;
        int n;
        nx = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                            n += int'(g[8 * (r + dr) + c + dc]);
                nx[8 * r + c] = (n == 3) || (g[8 * r + c] && n == 2);
            end
        return nx;
    endfunction

    assign grid_evolve = life_next(grid);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic load_grid(input logic [63:0] g, input logic hold_start);
        load_valid = 1'b1;
        start = hold_start;
        for (int i = 0; i < 8; i++) begin
            load_row = g[8 * i +: 8];
            chk("load_ready", 64'(load_ready), 64'd1);
            cyc(1);
            if (i == 0) chk("busy_in_load", 64'(busy), 64'd1);
        end
        load_valid = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_grid", grid, 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_flags", {60'd0, busy, stable, extinct, done}, 64'd0);
        chk("rst_ready", 64'(load_ready), 64'd1);
        cyc(2);
        reset_n = 1'b1;

        load_grid(BLINK_H, 1'b0);
        chk("blink_load", grid, BLINK_H);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("blink_step1", grid, BLINK_V);
        chk("blink_gen1", 64'(gen_count), 64'd1);
        cyc(1);
        chk("blink_idle_hold", grid, BLINK_V);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("blink_step2", grid, BLINK_H);
        chk("blink_gen2", 64'(gen_count), 64'd2);

        // start held through the whole load must not launch RUN
        load_grid(BLOCK, 1'b1);
        chk("block_load", grid, BLOCK);
        chk("load_clears_gen", 64'(gen_count), 64'd0);
        chk("start_ignored", 64'(busy), 64'd0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("block_busy", 64'(busy), 64'd1);
        cyc(3);
        chk("block_not_yet", 64'(stable), 64'd0);
        cyc(1);
        chk("block_stable", 64'(stable), 64'd1);
        chk("block_done", 64'(done), 64'd1);
        chk("block_busy_low", 64'(busy), 64'd0);
        chk("block_grid", grid, BLOCK);
        chk("block_gen", 64'(gen_count), 64'd0);
        cyc(1);
        chk("block_done_pulse", 64'(done), 64'd0);
        chk("block_stable_sticky", 64'(stable), 64'd1);

        load_grid(SINGLE, 1'b0);
        chk("single_flags_clr", 64'(stable), 64'd0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        chk("ext_grid", grid, 64'd0);
        chk("ext_gen", 64'(gen_count), 64'd1);
        chk("ext_not_yet", {62'd0, extinct, busy}, 64'd1);
        cyc(4);
        chk("ext_flag", 64'(extinct), 64'd1);
        chk("ext_done", 64'(done), 64'd1);
        chk("ext_gen_hold", 64'(gen_count), 64'd1);
        cyc(1);
        chk("ext_done_pulse", 64'(done), 64'd0);

        load_grid(GLIDER, 1'b0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(11);
        chk("glider_gen_pre", 64'(gen_count), 64'd2);
        chk("glider_grid_pre", grid, GLIDER2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_done", 64'(done), 64'd1);
        chk("stop_gen", 64'(gen_count), 64'd2);
        chk("stop_grid", grid, GLIDER2);
        chk("stop_flags", {61'd0, busy, stable, extinct}, 64'd0);
        cyc(1);
        chk("stop_idle", {62'd0, done, load_ready}, 64'd1);

        load_valid = 1'b1;
        load_row = 8'hFF;
        cyc(3);
        chk("partial_grid", grid[23:0], 64'h00FF_FFFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midload_rst_grid", grid, 64'd0);
        chk("midload_rst_busy", 64'(busy), 64'd0);
        load_valid = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        load_grid(SEED, 1'b0);
        chk("fresh_load", grid, SEED);
        chk("fresh_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
